// File: rtl/axis_rr_arb.sv
// Two-input AXI-Stream merge with packet-granular round-robin arbitration.
// Latency: one arbitration cycle per packet, then one cycle input to registered output.
// Backpressure: only the granted port sees tready, high while the output register is empty or draining.
module axis_rr_arb #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] s0_tdata,
    input  logic          s0_tvalid,
    input  logic          s0_tlast,
    output logic          s0_tready,
    input  logic [DW-1:0] s1_tdata,
    input  logic          s1_tvalid,
    input  logic          s1_tlast,
    output logic          s1_tready,
    output logic [DW-1:0] m_tdata,
    output logic          m_tvalid,
    output logic          m_tlast,
    input  logic          m_tready,
    output logic [1:0]    grant
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t state;
    logic   last_served;
    logic   out_free;
    logic   ld0;
    logic   ld1;

    // The output register can take a beat when empty or when its current beat leaves this cycle.
    assign out_free  = !m_tvalid || m_tready;
    assign s0_tready = !rst && (state == GNT0) && out_free;
    assign s1_tready = !rst && (state == GNT1) && out_free;
    assign ld0       = s0_tvalid && s0_tready;
    assign ld1       = s1_tvalid && s1_tready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            grant       <= 2'b00;
            last_served <= 1'b1;
            m_tvalid    <= 1'b0;
            m_tlast     <= 1'b0;
            m_tdata     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // On a tie the port not served last wins.
                    if (s0_tvalid && (!s1_tvalid || last_served)) begin
                        state <= GNT0;
                        grant <= 2'b01;
                    end else if (s1_tvalid) begin
                        state <= GNT1;
                        grant <= 2'b10;
                    end
                end
                GNT0: begin
                    if (ld0 && s0_tlast) begin
                        state       <= IDLE;
                        grant       <= 2'b00;
                        last_served <= 1'b0;
                    end
                end
                GNT1: begin
                    if (ld1 && s1_tlast) begin
                        state       <= IDLE;
                        grant       <= 2'b00;
                        last_served <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= 2'b00;
                end
            endcase

            if (ld0) begin
                m_tdata  <= s0_tdata;
                m_tlast  <= s0_tlast;
                m_tvalid <= 1'b1;
            end else if (ld1) begin
                m_tdata  <= s1_tdata;
                m_tlast  <= s1_tlast;
                m_tvalid <= 1'b1;
            end else if (m_tready) begin
                m_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axis_rr_arb.sv
// Randomized and directed bench for axis_rr_arb against a queue-based packet arbitration model.
module tb_axis_rr_arb;

    localparam int DW = 8;

    logic          clk;
    logic          rst;
    logic [DW-1:0] s0_tdata;
    logic          s0_tvalid;
    logic          s0_tlast;
    logic          s0_tready;
    logic [DW-1:0] s1_tdata;
    logic          s1_tvalid;
    logic          s1_tlast;
    logic          s1_tready;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tlast;
    logic          m_tready;
    logic [1:0]    grant;

    axis_rr_arb #(.DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .s0_tdata  (s0_tdata),
        .s0_tvalid (s0_tvalid),
        .s0_tlast  (s0_tlast),
        .s0_tready (s0_tready),
        .s1_tdata  (s1_tdata),
        .s1_tvalid (s1_tvalid),
        .s1_tlast  (s1_tlast),
        .s1_tready (s1_tready),
        .m_tdata   (m_tdata),
        .m_tvalid  (m_tvalid),
        .m_tlast   (m_tlast),
        .m_tready  (m_tready),
        .grant     (grant)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Beats are stored as {last, data}.
    logic [DW:0] src0[$];
    logic [DW:0] src1[$];
    logic [DW:0] mq[$];
    logic [DW:0] out_log[$];
    logic [1:0]  glog[$];
    logic        vlog[$];

    int owner       = -1;
    int last_served = 1;
    int cyc         = 0;
    int first_mv    = -1;
    int sent_beats  = 0;
    int vp0 = 100, vp1 = 100, rp = 100;
    bit tog   = 0;
    bit hold0 = 0;
    bit obs_s0r, obs_s1r;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic drive();
        if (src0.size() != 0 && !hold0 && $urandom_range(99) < vp0) begin
            s0_tvalid = 1'b1;
            {s0_tlast, s0_tdata} = src0[0];
        end else begin
            s0_tvalid = 1'b0;
            s0_tdata  = DW'($urandom);
            s0_tlast  = 1'($urandom);
        end
        if (src1.size() != 0 && $urandom_range(99) < vp1) begin
            s1_tvalid = 1'b1;
            {s1_tlast, s1_tdata} = src1[0];
        end else begin
            s1_tvalid = 1'b0;
            s1_tdata  = DW'($urandom);
            s1_tlast  = 1'($urandom);
        end
        if (tog) m_tready = !m_tready;
        else     m_tready = ($urandom_range(99) < rp);
    endtask

    // One clock: check outputs mid-cycle against the model, then advance model and stimulus.
    task automatic step();
        bit          r0, r1, acc0, acc1, drn;
        logic [1:0]  eg;
        logic [DW:0] h;
        @(negedge clk);
        eg = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
        r0 = !rst && owner == 0 && (mq.size() == 0 || m_tready);
        r1 = !rst && owner == 1 && (mq.size() == 0 || m_tready);
        chk("grant", 32'(grant), 32'(eg));
        chk("s0_tready", 32'(s0_tready), 32'(r0));
        chk("s1_tready", 32'(s1_tready), 32'(r1));
        chk("m_tvalid", 32'(m_tvalid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            h = mq[0];
            chk("m_beat", 32'({m_tlast, m_tdata}), 32'(h));
        end
        if (m_tvalid && first_mv < 0) first_mv = cyc;
        vlog.push_back(m_tvalid);
        glog.push_back(grant);
        obs_s0r = s0_tready;
        obs_s1r = s1_tready;
        acc0 = s0_tvalid && r0;
        acc1 = s1_tvalid && r1;
        drn  = !rst && mq.size() != 0 && m_tready;
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            owner       = -1;
            last_served = 1;
            mq.delete();
        end else begin
            if (drn) out_log.push_back(mq.pop_front());
            if (acc0) begin
                mq.push_back({s0_tlast, s0_tdata});
                void'(src0.pop_front());
                if (s0_tlast) begin
                    owner       = -1;
                    last_served = 0;
                end
            end else if (acc1) begin
                mq.push_back({s1_tlast, s1_tdata});
                void'(src1.pop_front());
                if (s1_tlast) begin
                    owner       = -1;
                    last_served = 1;
                end
            end else if (owner < 0 && (s0_tvalid || s1_tvalid)) begin
                owner = (s0_tvalid && (!s1_tvalid || last_served == 1)) ? 0 : 1;
            end
        end
        drive();
    endtask

    task automatic add_pkt(input int port, input int len, input int base, input int stride);
        for (int i = 0; i < len; i++) begin
            logic [DW:0] b;
            b = {(i == len - 1), DW'(base + i * stride)};
            if (port == 0) src0.push_back(b);
            else           src1.push_back(b);
            sent_beats++;
        end
    endtask

    task automatic do_reset(input int n);
        rst   = 1'b1;
        hold0 = 1'b0;
        src0.delete();
        src1.delete();
        drive();
        repeat (n) step();
        rst = 1'b0;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_m_tdata", 32'(m_tdata), 32'd0);
        chk("rst_m_tlast", 32'(m_tlast), 32'd0);
        out_log.delete();
        glog.delete();
        vlog.delete();
        sent_beats = 0;
    endtask

    task automatic run_drain(input int max);
        int n;
        n = 0;
        while ((src0.size() != 0 || src1.size() != 0 || mq.size() != 0) && n < max) begin
            step();
            n++;
        end
        chk("drain_timeout", 32'(n >= max), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, fi, li, cnt10, idx10;
        clk = 1'b0;
        rst = 1'b1;
        m_tready = 1'b0;
        drive();

        // Single 10-beat packet on port 0, sink always ready.
        do_reset(3);
        vp0 = 100; vp1 = 100; rp = 100; tog = 0;
        first_mv = -1;
        add_pkt(0, 10, 2, 2);
        drive();
        n = cyc;
        run_drain(100);
        step();
        chk("t1_latency", 32'(first_mv - n), 32'd2);
        chk("t1_count", 32'(out_log.size()), 32'd10);
        for (int i = 0; i < out_log.size(); i++)
            chk("t1_beat", 32'(out_log[i]), 32'({(i == 9), DW'(2 * i + 2)}));

        // Both ports saturated with 3-beat packets: strict alternation, one bubble each.
        do_reset(2);
        add_pkt(0, 3, 8'h10, 1); add_pkt(0, 3, 8'h13, 1);
        add_pkt(1, 3, 8'h20, 1); add_pkt(1, 3, 8'h23, 1);
        drive();
        run_drain(100);
        chk("t2_count", 32'(out_log.size()), 32'd12);
        for (int i = 0; i < out_log.size(); i++)
            chk("t2_order", 32'(out_log[i]),
                32'({(i % 3 == 2), DW'(((i / 3) % 2 == 0 ? 8'h10 : 8'h20) + (i / 6) * 3 + i % 3)}));
        fi = -1; li = -1; n = 0;
        for (int i = 0; i < vlog.size(); i++) if (vlog[i]) begin
            if (fi < 0) fi = i;
            li = i;
            n++;
        end
        chk("t2_window", 32'(li - fi + 1), 32'd15);
        chk("t2_ones", 32'(n), 32'd12);

        // Sink ready toggling every cycle.
        do_reset(2);
        tog = 1; m_tready = 1'b1;
        add_pkt(0, 10, 8'h30, 1);
        drive();
        run_drain(200);
        tog = 0;
        chk("t3_count", 32'(out_log.size()), 32'd10);
        for (int i = 0; i < out_log.size(); i++)
            chk("t3_beat", 32'(out_log[i]), 32'({(i == 9), DW'(8'h30 + i)}));

        // Single-beat packet on port 1.
        do_reset(1);
        add_pkt(1, 1, 8'hAA, 0);
        drive();
        run_drain(20);
        step();
        cnt10 = 0; idx10 = 0;
        for (int i = 0; i < glog.size(); i++) if (glog[i] == 2'b10) begin
            cnt10++;
            idx10 = i;
        end
        chk("t4_grant_cycles", 32'(cnt10), 32'd1);
        chk("t4_back_idle", 32'(glog[idx10 + 1]), 32'd0);
        chk("t4_beat", 32'(out_log[0]), 32'h1AA);

        // Reset mid-packet, then tie resolution must favour port 0 again.
        do_reset(2);
        add_pkt(0, 1, 8'h3F, 0);
        add_pkt(0, 10, 8'h40, 1);
        drive();
        n = 0;
        while (src0.size() > 7 && n < 40) begin step(); n++; end
        chk("t5_reach_beat3", 32'(src0.size()), 32'd7);
        rst = 1'b1;
        drive();
        step();
        chk("t5_rst_mvalid", 32'(m_tvalid), 32'd0);
        chk("t5_rst_grant", 32'(grant), 32'd0);
        rst = 1'b0;
        src0.delete();
        drive();
        step();
        chk("t5_s0_tready", 32'(obs_s0r), 32'd0);
        chk("t5_s1_tready", 32'(obs_s1r), 32'd0);
        chk("t5_idle_grant", 32'(grant), 32'd0);
        add_pkt(0, 2, 8'h50, 1);
        add_pkt(1, 2, 8'h60, 1);
        drive();
        step();
        chk("t5_tie_grant", 32'(grant), 32'd1);
        run_drain(50);
        do_reset(1);
        add_pkt(1, 2, 8'h90, 1);
        drive();
        step();
        chk("t5_p1_alone", 32'(grant), 32'd2);
        run_drain(50);

        // Port 0 stalls mid-packet while port 1 waits.
        do_reset(2);
        add_pkt(0, 6, 8'h70, 1);
        add_pkt(1, 2, 8'h80, 1);
        drive();
        repeat (3) step();
        hold0 = 1'b1;
        drive();
        repeat (4) begin
            step();
            chk("t6_grant_held", 32'(grant), 32'd1);
            chk("t6_s1_blocked", 32'(obs_s1r), 32'd0);
        end
        hold0 = 1'b0;
        drive();
        run_drain(50);
        chk("t6_p0_last", 32'(out_log[5]), 32'h175);
        chk("t6_p1_first", 32'(out_log[6]), 32'h080);

        // Randomized traffic and backpressure.
        do_reset(2);
        vp0 = 70; vp1 = 60; rp = 65;
        for (int p = 0; p < 30; p++) begin
            add_pkt(0, $urandom_range(1, 6), $urandom_range(255), 1);
            add_pkt(1, $urandom_range(1, 6), $urandom_range(255), 3);
        end
        drive();
        run_drain(4000);
        chk("rand_count", 32'(out_log.size()), 32'(sent_beats));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
